// File: rtl/ir_mem_unit_pkg.sv
// Shared definitions for the instruction-register / memory access unit.
package ir_mem_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10
    } mem_state_t;

    // Wait-state count at which an outstanding access is abandoned.
    localparam logic [3:0] TIMEOUT = 4'd15;

    typedef struct packed {
        mem_state_t  st;
        logic [3:0]  wait_cnt;
        logic [31:0] instr;
        logic [7:0]  mdr;
        logic        buserr;
        logic        we;
        logic [7:0]  wdata;
        logic [3:0]  lanes;
    } mem_regs_t;

endpackage

// File: rtl/ir_mem_unit_if.sv
// Controller/memory-side signal bundle of ir_mem_unit; slave is the unit's own view.
interface ir_mem_unit_if;
    logic        memread;
    logic        memwrite;
    logic        irwrite0;
    logic        irwrite1;
    logic        irwrite2;
    logic        irwrite3;
    logic [7:0]  writedata;
    logic [7:0]  memdata;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic        stall;
    logic        op0;
    logic        op1;
    logic        op2;
    logic        op3;
    logic        op4;
    logic        op5;
    logic [31:0] instr;
    logic [7:0]  mdr;
    logic        buserr;

    modport master (
        output memread, memwrite, irwrite0, irwrite1, irwrite2, irwrite3,
               writedata, memdata, mem_ready,
        input  mem_req, mem_we, mem_wdata, stall,
               op0, op1, op2, op3, op4, op5, instr, mdr, buserr
    );

    modport slave (
        input  memread, memwrite, irwrite0, irwrite1, irwrite2, irwrite3,
               writedata, memdata, mem_ready,
        output mem_req, mem_we, mem_wdata, stall,
               op0, op1, op2, op3, op4, op5, instr, mdr, buserr
    );
endinterface

// File: rtl/ir_mem_unit_latch2ph.sv
// Two-phase master/slave storage element: master follows d while ph2 is high,
// slave takes the master value when ph1 opens.
module latch2ph #(
    parameter int W = 1
) (
    input  logic         ph1,
    input  logic         ph2,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] master;

    always_latch begin
        if (ph2) master <= d;
    end

    // The master is closed for the whole ph1 pulse, so updating the slave as
    // ph1 opens gives the same result as a transparent slave latch.
    always_ff @(posedge ph1) begin
        q <= master;
    end
endmodule

// File: rtl/ir_mem_unit.sv
// Byte-wide memory access sequencer: assembles the instruction register and MDR,
// stalls the controller during an access and flags a sticky bus timeout.
module ir_mem_unit
    import ir_mem_unit_pkg::*;
(
    input  logic         ph1,
    input  logic         ph2,
    input  logic         reset,
    ir_mem_unit_if.slave bus
);
    mem_regs_t  r_q;
    mem_regs_t  r_d;
    mem_state_t state_d;
    logic       access_req;

    assign access_req = bus.memread | bus.memwrite;

    latch2ph #(.W($bits(mem_regs_t))) u_regs (
        .ph1 (ph1),
        .ph2 (ph2),
        .d   (r_d),
        .q   (r_q)
    );

    always_comb begin : next_state
        state_d = r_q.st;
        if (reset) begin
            state_d = IDLE;
        end else begin
            case (r_q.st)
                IDLE:    if (access_req) state_d = REQ;
                REQ:     if (bus.mem_ready || (r_q.wait_cnt == TIMEOUT)) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin : datapath
        r_d    = r_q;
        r_d.st = state_d;
        if (reset) begin
            r_d = '0;
        end else begin
            case (r_q.st)
                IDLE: begin
                    if (access_req) begin
                        r_d.we    = bus.memwrite;
                        r_d.wdata = bus.writedata;
                        r_d.lanes = {bus.irwrite3, bus.irwrite2, bus.irwrite1, bus.irwrite0};
                    end
                end
                REQ: begin
                    if (bus.mem_ready) begin
                        r_d.wait_cnt = 4'd0;
                        // A store (including read+write) never loads MDR or IR.
                        if (!r_q.we) begin
                            r_d.mdr = bus.memdata;
                            for (int i = 0; i < 4; i++) begin
                                if (r_q.lanes[i]) r_d.instr[8*i +: 8] = bus.memdata;
                            end
                        end
                    end else if (r_q.wait_cnt == TIMEOUT) begin
                        r_d.wait_cnt = 4'd0;
                        r_d.buserr   = 1'b1;
                    end else begin
                        r_d.wait_cnt = r_q.wait_cnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin : outputs
        bus.mem_req   = (r_q.st == REQ);
        bus.stall     = !reset && (((r_q.st == IDLE) && access_req) || (r_q.st == REQ));
        bus.mem_we    = r_q.we;
        bus.mem_wdata = r_q.wdata;
        bus.instr     = r_q.instr;
        bus.mdr       = r_q.mdr;
        bus.buserr    = r_q.buserr;
        bus.op0       = r_q.instr[26];
        bus.op1       = r_q.instr[27];
        bus.op2       = r_q.instr[28];
        bus.op3       = r_q.instr[29];
        bus.op4       = r_q.instr[30];
        bus.op5       = r_q.instr[31];
    end
endmodule

// File: doc/ir_mem_unit.md
IR_MEM_UNIT -- requirements
Module: ir_mem_unit

Interface
REQ-001 SHALL have ph1  input  1  two-phase clock, slave phase; state visible to logic after ph1.
REQ-002 SHALL have ph2  input  1  two-phase clock, master phase; next state sampled while ph2 high.
REQ-003 SHALL have reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have memread, memwrite  input  1 each  access requests from controller.
REQ-005 SHALL have irwrite0..irwrite3  input  1 each  IR byte-lane enables; irwrite3 selects instr[31:24], irwrite0 selects instr[7:0].
REQ-006 SHALL have writedata  input  8  store byte.
REQ-007 SHALL have memdata  input  8  read byte from memory.
REQ-008 SHALL have mem_ready  input  1  memory completion strobe.
REQ-009 SHALL have mem_req  output  1  memory request.
REQ-010 SHALL have mem_we  output  1  write qualifier.
REQ-011 SHALL have mem_wdata  output  8  store data.
REQ-012 SHALL have stall  output  1  freezes the controller FSM when high.
REQ-013 SHALL have op0..op5  output  1 each  instr[26]..instr[31].
REQ-014 SHALL have instr  output  32  assembled instruction.
REQ-015 SHALL have mdr  output  8  memory data register.
REQ-016 SHALL have buserr  output  1  sticky timeout flag.

Function
REQ-017 One cycle SHALL be one ph2/ph1 pair; all state SHALL be master/slave latch pairs; outputs SHALL change only after ph1.
REQ-018 The FSM SHALL have states IDLE, REQ, DONE.
REQ-019 From IDLE, a cycle with (memread|memwrite) SHALL transition to REQ; otherwise remain in IDLE.
REQ-020 In REQ, mem_ready=1 SHALL transition to DONE and capture the access; mem_ready=0 SHALL increment wait_cnt[3:0].
REQ-021 In REQ, wait_cnt==15 with mem_ready=0 SHALL set buserr, transition to DONE, and perform no capture.
REQ-022 DONE SHALL last exactly one cycle, then transition to IDLE; wait_cnt SHALL clear on entering DONE.
REQ-023 mem_req SHALL be 1 only in REQ.
REQ-024 mem_we SHALL equal the memwrite value latched on IDLE->REQ.
REQ-025 mem_wdata SHALL hold the writedata latched on IDLE->REQ.
REQ-026 stall SHALL be combinational: (IDLE & (memread|memwrite)) | REQ; stall SHALL be 0 in DONE, so the controller advances exactly once per access.
REQ-027 With memread and memwrite both high, write SHALL take priority: mem_we=1 and no capture.
REQ-028 Read capture SHALL load memdata into mdr and into every IR byte lane whose irwrite was latched high at IDLE->REQ; unselected lanes SHALL hold.
REQ-029 Minimum access latency SHALL be 2 cycles (IDLE->REQ, REQ->DONE with mem_ready), plus 1 per wait state.
REQ-030 mem_ready outside REQ SHALL be ignored.
REQ-031 buserr SHALL remain 1 until reset.
REQ-032 op5..op0 SHALL always equal instr[31:26].

Reset
REQ-033 reset high at a ph2 sample SHALL force IDLE, wait_cnt=0, instr=0, mdr=0, buserr=0, and latched mem_we/mem_wdata/lane enables to 0.
REQ-034 Reset asserted during REQ SHALL drop mem_req on the following cycle and SHALL perform no capture, even if mem_ready=1 in that cycle.
REQ-035 While reset is high, stall SHALL be 0.

Structure
REQ-036 State encodings (IDLE=2'b00, REQ=2'b01, DONE=2'b10) and TIMEOUT=15 SHALL live in the shared MIPS definitions include, alongside the controller parameters.
REQ-037 One sub-module, latch2ph (parameterised-width master/slave latch pair), SHALL implement every state element.

Verification
REQ-038 Fetch1: memread=1, irwrite3=1, mem_ready on the 1st REQ cycle, memdata=8'h8C -> instr=32'h8C000000, op5..op0=6'b100011, stall high for 2 cycles.
REQ-039 Four back-to-back fetches delivering 8'h20, 8'h08, 8'h00, 8'h05 -> instr=32'h20080005, op=6'b001000.
REQ-040 Store: memwrite=1, writedata=8'h5A, mem_ready after 3 wait cycles -> mem_req high for 4 cycles, mem_we=1, mem_wdata=8'h5A, mdr unchanged.
REQ-041 Read with mem_ready never asserted -> after 16 REQ cycles buserr=1, DONE reached, instr and mdr unchanged, stall drops.
REQ-042 Reset asserted on the 2nd REQ cycle with memdata=8'hFF and mem_ready=1 -> mem_req=0 next cycle; instr=0, mdr=0.
REQ-043 memread=memwrite=1, irwrite0=1 -> mem_we=1; instr[7:0] unchanged.
